// File: rtl/rx_peak_search.sv
// Windowed multi-channel correlation peak search with valid/ready result handoff.
// Optional feature macro: RX_PEAK_DROP_COUNT_EN adds o_drop_count (ignored crossings).
module rx_peak_search #(
    parameter int NCH = 16,
    parameter int DW  = 16,
    parameter int TW  = 33,
    parameter int WIN = 16368,
    parameter int SW  = $clog2(NCH)
) (
    input  logic              crx_clk,
    input  logic              rrx_rst,
    input  logic              erx_en,
    input  logic [TW-1:0]     icurrent_time,
    input  logic [DW-1:0]     ithreshold,
    input  logic [DW-1:0]     isample_filtered,
    input  logic              inew_sample_trigger,
    input  logic [NCH*DW-1:0] isample_correlation,
    input  logic              i_peak_ready,
    output logic [DW-1:0]     o_peak_value,
    output logic [SW-1:0]     o_peak_seq,
    output logic [TW-1:0]     o_peak_time,
    output logic              o_peak_valid,
`ifdef RX_PEAK_DROP_COUNT_EN
    output logic [7:0]        o_drop_count,
`endif
    output logic              o_busy
);

    localparam int CW = $clog2(WIN);
    localparam int IW = $clog2(NCH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                 crossing;
    logic                 arm;
    logic                 track;
    logic                 win_last;
    logic                 scan_last;
    logic [CW-1:0]        smp_cnt;
    logic [IW-1:0]        scan_idx;
    logic [SW-1:0]        scan_sel;

    logic signed [DW-1:0] corr     [NCH];
    logic signed [DW-1:0] max_val  [NCH];
    logic [TW-1:0]        max_time [NCH];

    logic signed [DW-1:0] best_val;
    logic [SW-1:0]        best_seq;
    logic [TW-1:0]        best_time;

    for (genvar c = 0; c < NCH; c++) begin : g_unpack
        assign corr[c] = $signed(isample_correlation[c*DW +: DW]);
    end

    assign crossing  = inew_sample_trigger &&
                       ($signed(isample_filtered) > $signed(ithreshold));
    assign win_last  = (smp_cnt == CW'(WIN - 1));
    assign scan_last = (scan_idx == IW'(NCH));
    assign scan_sel  = scan_idx[SW-1:0];

    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt = state;
        arm       = 1'b0;
        track     = 1'b0;
        case (state)
            S_IDLE: begin
                if (crossing) begin
                    state_nxt = S_ACQ;
                    arm       = 1'b1;
                end
            end
            S_ACQ: begin
                if (inew_sample_trigger) begin
                    track = 1'b1;
                    if (win_last) begin
                        state_nxt = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (scan_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_peak_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!erx_en) begin
            state_nxt = S_IDLE;
            arm       = 1'b0;
            track     = 1'b0;
        end
    end

    // The arming sample loads every channel, so maxima never start from 0.
    // NOTE: these per-channel registers carry no reset; they are always written on arming before being read.
    always_ff @(posedge crx_clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (arm || (track && (corr[c] > max_val[c]))) begin
                max_val[c]  <= corr[c];
                max_time[c] <= icurrent_time;
            end
        end
    end

    // The scan walks indices 0..NCH-1, then spends one more cycle committing the winner.
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            smp_cnt      <= '0;
            scan_idx     <= '0;
            best_val     <= '0;
            best_seq     <= '0;
            best_time    <= '0;
            o_peak_value <= '0;
            o_peak_seq   <= '0;
            o_peak_time  <= '0;
        end else if (!erx_en) begin
            smp_cnt      <= '0;
            scan_idx     <= '0;
            best_val     <= '0;
            best_seq     <= '0;
            best_time    <= '0;
            o_peak_value <= '0;
            o_peak_seq   <= '0;
            o_peak_time  <= '0;
        end else begin
            if (arm) begin
                smp_cnt <= CW'(1);
            end else if (track) begin
                smp_cnt <= win_last ? '0 : smp_cnt + CW'(1);
            end

            if (state == S_SCAN) begin
                if (scan_last) begin
                    scan_idx     <= '0;
                    o_peak_value <= best_val;
                    o_peak_seq   <= best_seq;
                    o_peak_time  <= best_time;
                end else begin
                    scan_idx <= scan_idx + IW'(1);
                    if ((scan_idx == '0) || (max_val[scan_sel] > best_val)) begin
                        best_val  <= max_val[scan_sel];
                        best_seq  <= scan_sel;
                        best_time <= max_time[scan_sel];
                    end
                end
            end
        end
    end

    assign o_peak_valid = (state == S_DONE);
    assign o_busy       = (state != S_IDLE);

`ifdef RX_PEAK_DROP_COUNT_EN
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            o_drop_count <= '0;
        end else if (!erx_en) begin
            o_drop_count <= '0;
        end else if (crossing && ((state == S_SCAN) || (state == S_DONE)) &&
                     (o_drop_count != 8'hFF)) begin
            o_drop_count <= o_drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_peak_search.sv
// Directed bench for rx_peak_search with NCH=4, WIN=8, threshold 100.
module tb_rx_peak_search;

    logic                crx_clk = 1'b0;
    logic                rrx_rst;
    logic                erx_en;
    logic [32:0]         icurrent_time;
    logic [15:0]         ithreshold;
    logic [15:0]         isample_filtered;
    logic                inew_sample_trigger;
    logic [63:0]         isample_correlation;
    logic                i_peak_ready;
    logic signed [15:0]  peak_value;
    logic [1:0]          peak_seq;
    logic [32:0]         peak_time;
    logic                peak_valid;
    logic                busy;
`ifdef RX_PEAK_DROP_COUNT_EN
    logic [7:0]          drop_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    rx_peak_search #(
        .NCH(4),
        .DW (16),
        .TW (33),
        .WIN(8)
    ) dut (
        .crx_clk            (crx_clk),
        .rrx_rst            (rrx_rst),
        .erx_en             (erx_en),
        .icurrent_time      (icurrent_time),
        .ithreshold         (ithreshold),
        .isample_filtered   (isample_filtered),
        .inew_sample_trigger(inew_sample_trigger),
        .isample_correlation(isample_correlation),
        .i_peak_ready       (i_peak_ready),
        .o_peak_value       (peak_value),
        .o_peak_seq         (peak_seq),
        .o_peak_time        (peak_time),
        .o_peak_valid       (peak_valid),
`ifdef RX_PEAK_DROP_COUNT_EN
        .o_drop_count       (drop_count),
`endif
        .o_busy             (busy)
    );

    always #5 crx_clk = ~crx_clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge crx_clk);
    endtask

    // One strobe spanning exactly one rising edge; inputs change on falling edges.
    task automatic strobe(input int f, input int c0, input int c1, input int c2,
                          input int c3, input longint t);
        isample_filtered    = 16'(f);
        isample_correlation = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
        icurrent_time       = 33'(t);
        inew_sample_trigger = 1'b1;
        @(negedge crx_clk);
        inew_sample_trigger = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_value"}, longint'(peak_value), 0);
        check({tag, "_seq"},   longint'(peak_seq),   0);
        check({tag, "_time"},  longint'(peak_time),  0);
        check({tag, "_valid"}, longint'(peak_valid), 0);
        check({tag, "_busy"},  longint'(busy),       0);
    endtask

    task automatic check_result(input string tag, input int v, input int s, input longint t);
        check({tag, "_valid"}, longint'(peak_valid), 1);
        check({tag, "_value"}, longint'(peak_value), v);
        check({tag, "_seq"},   longint'(peak_seq),   s);
        check({tag, "_time"},  longint'(peak_time),  t);
    endtask

    initial begin
        rrx_rst             = 1'b1;
        erx_en              = 1'b1;
        icurrent_time       = '0;
        ithreshold          = 16'd100;
        isample_filtered    = '0;
        inew_sample_trigger = 1'b0;
        isample_correlation = '0;
        i_peak_ready        = 1'b0;
        #12;
        check_cleared("reset");
        @(negedge crx_clk);
        rrx_rst = 1'b0;

        // Window A: channel 2 peaks at 500 on sample 5 (time 1005).
        strobe(101, 0, 0, 100, 0, 1000);
        check("arm_101_busy", longint'(busy), 1);
        strobe(0, 10,   0, 200, -10, 1001);
        strobe(0, 20,   0, 300, -20, 1002);
        strobe(0, 30, 300, 400, -30, 1003);
        strobe(0, 40,   0, 450, -40, 1004);
        strobe(0, 50,   0, 500, -50, 1005);
        strobe(0, 60,   0, 200, -60, 1006);
        strobe(0, 70,   0, 100, -70, 1007);
        check("a_scan_busy", longint'(busy), 1);
        tick(4);
        check("a_valid_e4", longint'(peak_valid), 0);
        tick(1);
        check_result("a", 500, 2, 1005);
        i_peak_ready = 1'b1;
        tick(1);
        i_peak_ready = 1'b0;
        check("a_hs_valid", longint'(peak_valid), 0);
        check("a_hs_busy",  longint'(busy),       0);

        // Threshold is strict: 100 does not arm.
        strobe(100, 0, 0, 0, 0, 1900);
        check("thr_eq_busy", longint'(busy), 0);

        // Window B: all negative, ties on -20 (ch1 early, ch3 later), strobes 3 clocks apart.
        strobe(101, -60, -20, -90, -30, 2000); tick(2);
        strobe(0,   -50, -40, -80, -25, 2001); tick(2);
        strobe(0,   -70, -20, -85, -20, 2002); tick(2);
        strobe(0,  -100,-100,-100,-100, 2003); tick(2);
        strobe(0,  -100,-100,-100,-100, 2004); tick(2);
        strobe(0,  -100, -20,-100, -20, 2005); tick(2);
        strobe(0,  -100,-100,-100,-100, 2006); tick(2);
        tick(10);
        check("b_acq_after7_valid", longint'(peak_valid), 0);
        check("b_acq_after7_busy",  longint'(busy),       1);
        strobe(0, -100, -100, -100, -100, 2007);
        tick(4);
        check("b_valid_e4", longint'(peak_valid), 0);
        tick(1);
        check_result("b", -20, 1, 2000);

        // Ready held low for 10 cycles while crossings with large samples arrive.
        for (int i = 0; i < 10; i++) strobe(500, 900, 900, 900, 900, 5000 + i);
        check_result("b_hold", -20, 1, 2000);
        i_peak_ready = 1'b1;
        strobe(500, 900, 900, 900, 900, 5100);
        i_peak_ready = 1'b0;
        check("b_hs_valid", longint'(peak_valid), 0);
        check("b_hs_busy",  longint'(busy),       0);
        tick(1);
        check("b_no_rearm", longint'(busy), 0);
`ifdef RX_PEAK_DROP_COUNT_EN
        check("drop_count", longint'(drop_count), 11);
`endif

        // Enable dropped mid-acquisition clears everything on the next edge.
        strobe(200, 1, 1, 1, 1, 3000);
        strobe(0,   1, 1, 1, 1, 3001);
        strobe(0,   1, 1, 1, 1, 3002);
        check("c_acq_busy", longint'(busy), 1);
        erx_en = 1'b0;
        tick(1);
        erx_en = 1'b1;
        check_cleared("c_en_acq");

        // Window D: channel 3 reaches 7 at time 3004; then enable dropped in DONE.
        for (int k = 0; k < 8; k++)
            strobe((k == 0) ? 200 : 0, 0, 0, 0, (k == 4) ? 7 : 1, 3000 + k);
        tick(5);
        check_result("d", 7, 3, 3004);
        erx_en = 1'b0;
        tick(1);
        erx_en = 1'b1;
        check_cleared("d_en_done");

        // Window E: all channels flat at 5 -> channel 0, first timestamp; then async reset.
        for (int k = 0; k < 8; k++)
            strobe((k == 0) ? 150 : 0, 5, 5, 5, 5, 4000 + k);
        tick(5);
        check_result("e", 5, 0, 4000);
        #2;
        rrx_rst = 1'b1;
        #1;
        check_cleared("e_async_rst");
        @(negedge crx_clk);
        rrx_rst = 1'b0;
        tick(1);
        check("e_post_rst_busy", longint'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
